// File: rtl/noc_yummy_rx.sv
// ----------------------------------------------------------------------------
// noc_yummy_rx
//
// Link-receiver endpoint for the credit-based ("yummy") NoC link protocol.
// Flits arriving from a neighbouring router are stored in a DEPTH-entry FIFO
// and offered to a local consumer over a valid/ready handshake. Every flit
// the consumer takes is returned to the sender as a one-cycle yummy (credit)
// pulse, registered so there is no combinational path from out_ready.
//
// The sending router starts with DEPTH credits, so a flit arriving while the
// FIFO is full is a protocol violation. Such a flit is always dropped. When
// the NOC_YUMMY_RX_CHK_EN macro is defined, a sticky ovf_err flag records the
// violation and a simulation-only $error is raised. When the macro is not
// defined, ovf_err is tied low and no check logic exists.
//
// Parameters:
//   WIDTH  flit width (matches the link data/response width)
//   DEPTH  FIFO entries; power of two, >= 2, equal to sender's credit count
//   CNT_W  occupancy counter width (derived)
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   link_in         flit from neighbour router output
//   link_vld_in     flit valid, one flit per cycle when high
//   link_yummy_out  credit-return pulse to neighbour yummy input
//   out_data        head-of-FIFO flit (meaningful only while out_valid)
//   out_valid       FIFO non-empty
//   out_ready       consumer accepts the head when high with out_valid
//   occupancy       current entry count, 0..DEPTH
//   ovf_err         sticky overflow flag (only with NOC_YUMMY_RX_CHK_EN)
// ----------------------------------------------------------------------------
module noc_yummy_rx #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] link_in,
    input  logic             link_vld_in,
    output logic             link_yummy_out,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] occupancy,
    output logic             ovf_err
);

    // Pointer width; DEPTH is a power of two so pointers wrap by overflow.
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             yummy_q;
    logic             full;
    logic             enq;
    logic             deq;

    // The full test uses the registered count only. A dequeue in the same
    // cycle does not make room, because its credit has not reached the
    // sender yet, so an arrival at full is always a violation and is dropped.
    assign full      = (count == FULL_CNT);
    assign enq       = link_vld_in & ~full;
    assign out_valid = (count != '0);
    assign deq       = out_valid & out_ready;

    // The head is read straight from storage. out_valid comes from the
    // registered count, so a flit written this cycle is not visible until
    // the following cycle.
    assign out_data       = mem[rd_ptr];
    assign occupancy      = count;
    assign link_yummy_out = yummy_q;

    // Pointers and occupancy. Reset discards every stored flit. Enqueue and
    // dequeue in the same cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Flit storage. It is not reset because its contents are don't-care
    // while the FIFO is empty. Only accepted flits are written.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= link_in;
        end
    end

    // One credit per dequeue, issued in the cycle after the handshake.
    // Back-to-back dequeues give back-to-back pulses. Reset cancels any
    // credit that has not been issued yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            yummy_q <= 1'b0;
        end else begin
            yummy_q <= deq;
        end
    end

`ifdef NOC_YUMMY_RX_CHK_EN
    logic ovf_q;

    // Sticky overflow flag. It sets on any arrival at full and clears only
    // on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (link_vld_in && full) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf_err = ovf_q;

`ifndef SYNTHESIS
    // Report the violation in simulation in the cycle it happens.
    always_ff @(posedge clk) begin
        if (!rst && link_vld_in && full) begin
            $error("noc_yummy_rx: flit arrived while FIFO full, flit dropped");
        end
    end
`endif
`else
    assign ovf_err = 1'b0;
`endif

endmodule

// File: doc/noc_yummy_rx.md
# noc_yummy_rx

Link-receiver endpoint for the credit-based ("yummy") NoC link protocol: it terminates one `dat_*_out`/`dat_vld_*_out`/`dat_yummy_*_in` triple driven by a router output port. Incoming flits land in a DEPTH-entry FIFO and are presented to a local consumer over a valid/ready handshake. Each flit the consumer takes returns one credit to the sending router as a single-cycle yummy pulse. The block sits on mesh-edge ports and in off-router endpoints, opposite a router whose credit count equals DEPTH.

## Interface
Parameters:
- WIDTH, 64: flit width; must equal the link `DATA_WIDTH` or `RSP_WIDTH`.
- DEPTH, 4: FIFO entries. Must be a power of two, ≥2, and equal to the sender's initial credit count.
- CNT_W, $clog2(DEPTH+1): occupancy counter width (derived).

Ports:
- clk, input, 1: clock; everything is single-clock and rising-edge.
- rst, input, 1: reset, synchronous and active-high.
- link_in, input, WIDTH: flit from neighbour router `*_out`.
- link_vld_in, input, 1: flit valid; one flit per cycle when high.
- link_yummy_out, output, 1: credit-return pulse to neighbour `*_yummy_in`.
- out_data, output, WIDTH: head-of-FIFO flit.
- out_valid, output, 1: FIFO non-empty.
- out_ready, input, 1: consumer accepts head when high together with out_valid.
- occupancy, output, CNT_W: current entry count, 0..DEPTH.
- ovf_err, output, 1: sticky overflow flag (see Configuration).

## Operation
- Enqueue: if link_vld_in=1 and occupancy<DEPTH, write link_in at wr_ptr and increment wr_ptr (mod DEPTH).
- Dequeue: if out_valid & out_ready, increment rd_ptr (mod DEPTH).
- Occupancy: +1 on enqueue-only, −1 on dequeue-only, unchanged on both or neither.
- out_data = mem[rd_ptr]. It is valid only while out_valid=1 and holds stable until dequeued.
- Yummy: link_yummy_out is asserted for exactly one cycle per dequeue. Back-to-back dequeues give back-to-back pulses, with no merging and no loss.
- Full arrival: link_vld_in=1 while occupancy==DEPTH is a protocol violation. It applies even if a dequeue happens in the same cycle, because that credit has not been returned yet. The flit is dropped and FIFO state is unchanged except for the concurrent dequeue.
- Empty: out_valid=0. out_ready is ignored and no yummy is generated.
- Pointers wrap naturally at DEPTH, since DEPTH is a power of two.
- No flow-through path: a flit arriving at cycle t is never visible on out_data at cycle t.

## Timing
- Reset values: out_valid=0, link_yummy_out=0, occupancy=0, ovf_err=0, pointers=0. out_data is don't-care.
- Arrival-to-output latency is 1 cycle. A flit with link_vld_in at edge t gives out_valid=1 after edge t, even if the FIFO was empty.
- Dequeue-to-yummy latency is 1 cycle. A handshake at edge t gives link_yummy_out=1 for the cycle after edge t. The yummy is registered, with no combinational path from out_ready.
- Sustained throughput is 1 flit/cycle with out_ready held high and DEPTH≥2.
- Reset mid-operation: all stored flits are discarded, any pending yummy is cancelled, and no yummies are issued for discarded flits. The sender must be reset in the same cycle.
- rst has priority over all simultaneous link_vld_in and out_ready activity.

## Configuration
- NOC_YUMMY_RX_CHK_EN defined:
  - ovf_err sets on any full-arrival violation and stays set until rst.
  - A simulation-only `$error` fires in the same cycle.
- NOC_YUMMY_RX_CHK_EN undefined:
  - ovf_err is tied to 0 and no check logic is generated.
  - The drop-on-full behaviour is unchanged.

## Test plan
- Single flit: after rst, link_vld_in=1 with link_in=0xA5 for one cycle, and out_ready=1 → next cycle out_valid=1 with out_data=0xA5 and the handshake completes; link_yummy_out=1 for exactly one cycle after that; occupancy returns to 0.
- Fill/drain (DEPTH=4): with out_ready=0, send 4 flits 1..4 → occupancy=4 and no yummies. Then set out_ready=1 → data 1,2,3,4 come out in order, followed by 4 consecutive single-cycle yummy pulses.
- Streaming with wrap: 20 flits, one per cycle, with out_ready=1 → all 20 come out in order and occupancy stays ≤1. Yummy count equals 20.
- Overflow: with the FIFO full, drive a 5th flit 0xFF. With the macro defined, ovf_err=1 from the next cycle and stays high; the drained data is 1..4 only. Without the macro, ovf_err stays 0 and the data is the same.
- Simultaneous: at occupancy=2, enqueue and dequeue in the same cycle → occupancy stays 2, one yummy is issued, and ordering is preserved.
- Reset mid-stream: with 3 flits queued and a yummy pending, assert rst for 1 cycle → next cycle out_valid=0, occupancy=0, link_yummy_out=0, and no further yummies.
